ddr_req_arbiter: RTL

Round-robin arbiter that shares the single DDR controller command/write-data port among NUM_REQ requesters. It sits between the client blocks and the controller's command input and issues one command per handshake. It records the owner of every issued read in an in-order routing FIFO so that returning read data is steered back to the requester that asked for it.

---
 rtl/userType_pkg.sv | 28 ++
 rtl/ddr_rd_route_fifo.sv | 60 ++++++
 rtl/ddr_req_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/userType_pkg.sv
// Shared DDR controller types, plus the request-arbiter defaults and id type.
package userType_pkg;

    localparam int unsigned DQ_BITS          = 4;
    localparam int unsigned NUM_REQ_DEFAULT  = 4;
    localparam int unsigned RD_DEPTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        CmdNop,
        CmdRead,
        CmdWrite,
        CmdRefresh
    } cmd_op_e;

    typedef struct packed {
        cmd_op_e     op;
        logic [2:0]  bank;
        logic [14:0] row;
        logic [9:0]  col;
    } command_t;

    typedef logic [2:0] req_id_t;

    function automatic logic [7:0] id_to_onehot(req_id_t id);
        return 8'(1) << id;
    endfunction

endpackage

// File: rtl/ddr_rd_route_fifo.sv
// In-order FIFO of requester ids for outstanding reads; the head id names the owner
// of the next read beat returned by the controller.
module ddr_rd_route_fifo
    import userType_pkg::*;
#(
    parameter int unsigned Depth = RD_DEPTH_DEFAULT,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  req_id_t         push_id,
    input  logic            pop,
    output req_id_t         head_id,
    output logic [CntW-1:0] count,
    output logic            empty,
    output logic            full
);

    req_id_t         mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CntW'(Depth));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head_id = mem[rd_ptr];

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CntW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

endmodule

// File: rtl/ddr_req_arbiter.sv
// Round-robin arbiter sharing the DDR command port and steering read data back to its owner.
// Define ARB_PRIO0_EN to give requester 0 strict priority over a round-robin of the rest.
module ddr_req_arbiter
    import userType_pkg::*;
#(
    parameter int unsigned NUM_REQ  = NUM_REQ_DEFAULT,
    parameter int unsigned RD_DEPTH = RD_DEPTH_DEFAULT,
    parameter int unsigned DATA_W   = DQ_BITS * 8,
    localparam int unsigned CNT_W   = $clog2(RD_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           power_on_rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_is_read,
    input  command_t [NUM_REQ-1:0]         req_command,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_write_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_W-1:0]              rsp_data,
    output command_t                       command,
    output logic                           valid,
    output logic [DATA_W-1:0]              write_data,
    input  logic                           cmd_ready,
    input  logic [DATA_W-1:0]              read_data,
    input  logic                           read_data_valid,
    output logic [CNT_W-1:0]               rd_outstanding,
    output logic                           rsp_orphan_err
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] eligible;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic               slot_free;
    logic               rd_full;
    logic               fifo_empty;
    logic               push_rd;
    req_id_t            head_id;

    assign slot_free = ~valid | cmd_ready;
    // Reads are held off while the routing FIFO is full, even if a pop happens this cycle.
    assign eligible  = req_valid & (~req_is_read | {NUM_REQ{~rd_full}});

    always_comb begin
        int unsigned idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
`ifdef ARB_PRIO0_EN
        if (eligible[0]) begin
            grant_any = 1'b1;
        end
        // Requesters 1..NUM_REQ-1 rotate among themselves; rr_ptr never points at 0.
        for (int unsigned k = 1; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - (NUM_REQ - 1);
            end
            if (!grant_any && eligible[IDX_W'(idx)]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
`else
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_any && eligible[IDX_W'(idx)]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
`endif
        if (!slot_free || !power_on_rst_n) begin
            grant_any = 1'b0;
        end
    end

    assign req_ready = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
    assign push_rd   = grant_any & req_is_read[grant_idx];

    ddr_rd_route_fifo #(
        .Depth (RD_DEPTH)
    ) u_route_fifo (
        .clk     (clk),
        .rst_n   (power_on_rst_n),
        .push    (push_rd),
        .push_id (req_id_t'(grant_idx)),
        .pop     (read_data_valid),
        .head_id (head_id),
        .count   (rd_outstanding),
        .empty   (fifo_empty),
        .full    (rd_full)
    );

    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            valid          <= 1'b0;
            command        <= '0;
            write_data     <= '0;
            rr_ptr         <= IDX_W'(NUM_REQ - 1);
            rsp_valid      <= '0;
            rsp_data       <= '0;
            rsp_orphan_err <= 1'b0;
        end else begin
            if (grant_any) begin
                valid      <= 1'b1;
                command    <= req_command[grant_idx];
                write_data <= req_write_data[grant_idx];
            end else if (cmd_ready) begin
                valid <= 1'b0;
            end
`ifdef ARB_PRIO0_EN
            if (grant_any && grant_idx != '0) begin
                rr_ptr <= grant_idx;
            end
`else
            if (grant_any) begin
                rr_ptr <= grant_idx;
            end
`endif
            rsp_valid <= '0;
            if (read_data_valid) begin
                if (fifo_empty) begin
                    rsp_orphan_err <= 1'b1;
                end else begin
                    rsp_valid <= NUM_REQ'(id_to_onehot(head_id));
                    rsp_data  <= read_data;
                end
            end
        end
    end

endmodule
